// File: rtl/regs_wport_arb_if.sv
// Register-file write-port arbiter bus.
// Bundles the ex writeback, the divider and JTAG request/ready handshakes,
// the stall request, the shared register-file write port and busy status.
//   master : the environment (pipeline, divider, JTAG, register file)
//   slave  : the arbiter
interface regs_wport_arb_if #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32
);
  logic             ex_we_i;
  logic [AddrW-1:0] ex_waddr_i;
  logic [DataW-1:0] ex_wdata_i;
  logic             div_valid_i;
  logic             div_ready_o;
  logic [AddrW-1:0] div_waddr_i;
  logic [DataW-1:0] div_wdata_i;
  logic             jtag_valid_i;
  logic             jtag_ready_o;
  logic [AddrW-1:0] jtag_addr_i;
  logic [DataW-1:0] jtag_wdata_i;
  logic             ex_stall_o;
  logic             rf_we_o;
  logic [AddrW-1:0] rf_waddr_o;
  logic [DataW-1:0] rf_wdata_o;
  logic             busy_o;

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output div_valid_i, div_waddr_i, div_wdata_i,
    output jtag_valid_i, jtag_addr_i, jtag_wdata_i,
    input  div_ready_o, jtag_ready_o, ex_stall_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
  );

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  div_valid_i, div_waddr_i, div_wdata_i,
    input  jtag_valid_i, jtag_addr_i, jtag_wdata_i,
    output div_ready_o, jtag_ready_o, ex_stall_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
  );
endinterface

// File: rtl/regs_wport_arb.sv
// Write-port arbiter for the general-purpose register file.
// ex writeback always owns the port. Divider and JTAG writes are parked in
// one-entry slots and drained round-robin in cycles where ex does not write.
// A starvation counter raises ex_stall_o so held writes are guaranteed to drain.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     arbiter side (slave modport) of regs_wport_arb_if:
//           ex_* writeback in, div_*/jtag_* valid/ready slots,
//           rf_* shared write port out, ex_stall_o, busy_o
// StarveMax legal range is 1..255.
module regs_wport_arb #(
  parameter int unsigned AddrW     = 5,
  parameter int unsigned DataW     = 32,
  parameter int unsigned StarveMax = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  regs_wport_arb_if.slave  bus
);

  localparam logic [7:0] StarveMaxC = 8'(StarveMax);

  typedef enum logic [1:0] {StIdle, StWait, StStall} state_e;

  state_e           state_q, state_d;
  logic             div_vld_q, div_vld_d, div_rdy_q, div_rdy_d;
  logic             jtag_vld_q, jtag_vld_d, jtag_rdy_q, jtag_rdy_d;
  logic [AddrW-1:0] div_addr_q, jtag_addr_q;
  logic [DataW-1:0] div_data_q, jtag_data_q;
  logic             rr_q, rr_d;  // 1: jtag wins the next contention
  logic [7:0]       cnt_q, cnt_d;

  logic             div_acc, div_fill, jtag_acc, jtag_fill;
  logic             div_drain, jtag_drain, drain, busy, any_d, ex_win;
  logic             rf_we;
  logic [AddrW-1:0] rf_waddr;
  logic [DataW-1:0] rf_wdata;

  // Writes to x0 are accepted (handshake completes) but never occupy a slot.
  assign div_acc   = bus.div_valid_i & div_rdy_q;
  assign div_fill  = div_acc & (|bus.div_waddr_i);
  assign jtag_acc  = bus.jtag_valid_i & jtag_rdy_q;
  assign jtag_fill = jtag_acc & (|bus.jtag_addr_i);

  // Gated by reset so the port stays quiet while rst_ni is low.
  assign ex_win = rst_ni & bus.ex_we_i & (|bus.ex_waddr_i);

  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    div_drain  = 1'b0;
    jtag_drain = 1'b0;
    rr_d       = rr_q;
    if (ex_win) begin
      rf_we    = 1'b1;
      rf_waddr = bus.ex_waddr_i;
      rf_wdata = bus.ex_wdata_i;
    end else if (div_vld_q && jtag_vld_q) begin
      // Pointer only moves on contention.
      if (rr_q) begin
        jtag_drain = 1'b1;
        rr_d       = 1'b0;
      end else begin
        div_drain = 1'b1;
        rr_d      = 1'b1;
      end
    end else if (div_vld_q) begin
      div_drain = 1'b1;
    end else if (jtag_vld_q) begin
      jtag_drain = 1'b1;
    end

    if (div_drain) begin
      rf_we    = 1'b1;
      rf_waddr = div_addr_q;
      rf_wdata = div_data_q;
    end else if (jtag_drain) begin
      rf_we    = 1'b1;
      rf_waddr = jtag_addr_q;
      rf_wdata = jtag_data_q;
    end
  end

  assign drain = div_drain | jtag_drain;
  assign busy  = div_vld_q | jtag_vld_q;

  // Ready stays low the cycle after any accept (even to x0) and the cycle
  // a slot drains, so a slot is never refilled in its drain cycle.
  assign div_vld_d  = div_fill | (div_vld_q & ~div_drain);
  assign jtag_vld_d = jtag_fill | (jtag_vld_q & ~jtag_drain);
  assign div_rdy_d  = ~(div_vld_d | div_acc);
  assign jtag_rdy_d = ~(jtag_vld_d | jtag_acc);
  assign any_d      = div_vld_d | jtag_vld_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!busy || drain) begin
      cnt_d = '0;
    end else if (cnt_q < StarveMaxC) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_d) state_d = StWait;
      end
      StWait: begin
        if (!any_d) begin
          state_d = StIdle;
        end else if (cnt_d == StarveMaxC) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (drain) state_d = any_d ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      div_vld_q   <= 1'b0;
      div_rdy_q   <= 1'b1;
      jtag_vld_q  <= 1'b0;
      jtag_rdy_q  <= 1'b1;
      div_addr_q  <= '0;
      div_data_q  <= '0;
      jtag_addr_q <= '0;
      jtag_data_q <= '0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      div_vld_q  <= div_vld_d;
      div_rdy_q  <= div_rdy_d;
      jtag_vld_q <= jtag_vld_d;
      jtag_rdy_q <= jtag_rdy_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      if (div_fill) begin
        div_addr_q <= bus.div_waddr_i;
        div_data_q <= bus.div_wdata_i;
      end
      if (jtag_fill) begin
        jtag_addr_q <= bus.jtag_addr_i;
        jtag_data_q <= bus.jtag_wdata_i;
      end
    end
  end

  assign bus.div_ready_o  = div_rdy_q;
  assign bus.jtag_ready_o = jtag_rdy_q;
  assign bus.ex_stall_o   = (state_q == StStall);
  assign bus.rf_we_o      = rf_we;
  assign bus.rf_waddr_o   = rf_waddr;
  assign bus.rf_wdata_o   = rf_wdata;
  assign bus.busy_o       = busy;

endmodule

// File: tb/tb_regs_wport_arb.sv
module tb_regs_wport_arb;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  regs_wport_arb_if #(.AddrW(5), .DataW(32)) bus ();

  regs_wport_arb #(.AddrW(5), .DataW(32), .StarveMax(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    bus.ex_we_i      = 1'b0;
    bus.ex_waddr_i   = '0;
    bus.ex_wdata_i   = '0;
    bus.div_valid_i  = 1'b0;
    bus.div_waddr_i  = '0;
    bus.div_wdata_i  = '0;
    bus.jtag_valid_i = 1'b0;
    bus.jtag_addr_i  = '0;
    bus.jtag_wdata_i = '0;
  endtask

  task automatic ex_wr(input logic [4:0] a, input logic [31:0] d);
    bus.ex_we_i    = 1'b1;
    bus.ex_waddr_i = a;
    bus.ex_wdata_i = d;
  endtask

  task automatic div_wr(input logic [4:0] a, input logic [31:0] d);
    bus.div_valid_i = 1'b1;
    bus.div_waddr_i = a;
    bus.div_wdata_i = d;
  endtask

  task automatic jtag_wr(input logic [4:0] a, input logic [31:0] d);
    bus.jtag_valid_i = 1'b1;
    bus.jtag_addr_i  = a;
    bus.jtag_wdata_i = d;
  endtask

  // Expected port write: we, addr, data.
  task automatic check_rf(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
    check_eq({tag, ".we"}, 32'(bus.rf_we_o), 32'(we));
    check_eq({tag, ".addr"}, 32'(bus.rf_waddr_o), 32'(a));
    check_eq({tag, ".data"}, bus.rf_wdata_o, d);
  endtask

  task automatic check_status(input string tag, input logic busy, input logic drdy,
                              input logic jrdy, input logic stall);
    check_eq({tag, ".busy"}, 32'(bus.busy_o), 32'(busy));
    check_eq({tag, ".div_rdy"}, 32'(bus.div_ready_o), 32'(drdy));
    check_eq({tag, ".jtag_rdy"}, 32'(bus.jtag_ready_o), 32'(jrdy));
    check_eq({tag, ".stall"}, 32'(bus.ex_stall_o), 32'(stall));
  endtask

  initial begin
    idle_in();
    // ex write during reset must not reach the port.
    ex_wr(5'd5, 32'h1234_5678);
    repeat (2) @(posedge clk_i);
    #1;
    check_rf("rst", 1'b0, 5'd0, 32'h0);
    check_status("rst", 1'b0, 1'b1, 1'b1, 1'b0);
    idle_in();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_rf("idle", 1'b0, 5'd0, 32'h0);
    check_status("idle", 1'b0, 1'b1, 1'b1, 1'b0);

    // ex and divider in the same cycle.
    ex_wr(5'd5, 32'hAAAA_0001);
    div_wr(5'd7, 32'h0000_00D1);
    #1;
    check_rf("exdiv.c0", 1'b1, 5'd5, 32'hAAAA_0001);
    check_status("exdiv.c0", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle_in();
    #1;
    check_rf("exdiv.c1", 1'b1, 5'd7, 32'h0000_00D1);
    check_status("exdiv.c1", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_rf("exdiv.c2", 1'b0, 5'd0, 32'h0);
    check_status("exdiv.c2", 1'b0, 1'b1, 1'b1, 1'b0);

    // Round-robin: first pair div first, second pair jtag first.
    div_wr(5'd3, 32'h0000_0033);
    jtag_wr(5'd4, 32'h0000_0044);
    #1;
    check_rf("rr1.fill", 1'b0, 5'd0, 32'h0);
    tick();
    idle_in();
    #1;
    check_rf("rr1.d0", 1'b1, 5'd3, 32'h0000_0033);
    check_status("rr1.d0", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_rf("rr1.d1", 1'b1, 5'd4, 32'h0000_0044);
    check_status("rr1.d1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_rf("rr1.end", 1'b0, 5'd0, 32'h0);
    check_status("rr1.end", 1'b0, 1'b1, 1'b1, 1'b0);
    div_wr(5'd3, 32'h0000_0333);
    jtag_wr(5'd4, 32'h0000_0444);
    tick();
    idle_in();
    #1;
    check_rf("rr2.d0", 1'b1, 5'd4, 32'h0000_0444);
    tick();
    check_rf("rr2.d1", 1'b1, 5'd3, 32'h0000_0333);
    tick();
    check_rf("rr2.end", 1'b0, 5'd0, 32'h0);
    check_status("rr2.end", 1'b0, 1'b1, 1'b1, 1'b0);

    // JTAG write to x0: consumed, ready drops one cycle, no port write.
    jtag_wr(5'd0, 32'hDEAD_BEEF);
    #1;
    check_rf("x0.c0", 1'b0, 5'd0, 32'h0);
    tick();
    idle_in();
    #1;
    check_rf("x0.c1", 1'b0, 5'd0, 32'h0);
    check_status("x0.c1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_rf("x0.c2", 1'b0, 5'd0, 32'h0);
    check_status("x0.c2", 1'b0, 1'b1, 1'b1, 1'b0);

    // Starvation: div held while ex writes x1 every cycle.
    div_wr(5'd9, 32'h0000_0099);
    ex_wr(5'd1, 32'h0000_0100);
    #1;
    check_rf("stv.fill", 1'b1, 5'd1, 32'h0000_0100);
    tick();
    bus.div_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      ex_wr(5'd1, 32'h0000_0100 + 32'(k));
      #1;
      check_rf($sformatf("stv.k%0d", k), 1'b1, 5'd1, 32'h0000_0100 + 32'(k));
      check_status($sformatf("stv.k%0d", k), 1'b1, 1'b0, 1'b1, k >= 9);
      tick();
    end
    idle_in();
    #1;
    check_rf("stv.drain", 1'b1, 5'd9, 32'h0000_0099);
    check_status("stv.drain", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_rf("stv.after", 1'b0, 5'd0, 32'h0);
    check_status("stv.after", 1'b0, 1'b1, 1'b1, 1'b0);

    // Drain and refill in the same cycle is refused; accepted next cycle.
    div_wr(5'd10, 32'h0000_000A);
    tick();
    div_wr(5'd11, 32'h0000_000B);
    #1;
    check_rf("refill.r1", 1'b1, 5'd10, 32'h0000_000A);
    check_status("refill.r1", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_rf("refill.r2", 1'b0, 5'd0, 32'h0);
    check_status("refill.r2", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle_in();
    #1;
    check_rf("refill.r3", 1'b1, 5'd11, 32'h0000_000B);
    check_status("refill.r3", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_status("refill.r4", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-operation discards the held write.
    ex_wr(5'd2, 32'h0000_0022);
    div_wr(5'd12, 32'h0000_00CC);
    tick();
    bus.div_valid_i = 1'b0;
    #1;
    check_status("midrst.held", 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    idle_in();
    #1;
    check_rf("midrst.in", 1'b0, 5'd0, 32'h0);
    check_status("midrst.in", 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_rf("midrst.c0", 1'b0, 5'd0, 32'h0);
    check_status("midrst.c0", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_rf("midrst.c1", 1'b0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
